// File: rtl/dcache_warmup_pkg.sv
// Shared geometry, FSM state encoding and record layout for the dcache warmup sequencer.
package dcache_warmup_pkg;

  localparam int SETS        = 64;
  localparam int WAYS        = 4;
  localparam int TAG_BITS    = 22;
  localparam int BLOCK_BYTES = 64;
  localparam int ROW_BITS    = 64;
  localparam int BEATS       = BLOCK_BYTES * 8 / ROW_BITS;
  localparam int ROW_BYTES   = ROW_BITS / 8;

  localparam int SET_W       = $clog2(SETS);
  localparam int WAY_W       = $clog2(WAYS);
  localparam int BEAT_W      = $clog2(BEATS);
  localparam int BLOCK_BITS  = BLOCK_BYTES * 8;

  localparam int TAG_ROW_W   = WAYS * TAG_BITS;
  localparam int TAG_MASK_W  = WAYS;
  localparam int DATA_ROW_W  = WAYS * ROW_BITS;
  localparam int DATA_MASK_W = WAYS * ROW_BYTES;
  localparam int DATA_ADDR_W = SET_W + BEAT_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [SET_W-1:0]      set;
    logic [WAY_W-1:0]      way;
    logic [TAG_BITS-1:0]   tag;
    logic [BLOCK_BITS-1:0] data;
    logic                  last;
  } warmup_rec_t;

endpackage

// File: rtl/dcache_warmup_sequencer_if.sv
// Record stream plus the RW0 ports of the dcache tag and data SRAMs.
interface dcache_warmup_sequencer_if;
  import dcache_warmup_pkg::*;

  // Record handshake: a record transfers on every rising clk edge where
  // rec_valid and rec_ready are both high; the source holds rec_* stable
  // while rec_valid is high and rec_ready is low.
  logic                    rec_valid;
  logic                    rec_ready;
  logic [SET_W-1:0]        rec_set;
  logic [WAY_W-1:0]        rec_way;
  logic [TAG_BITS-1:0]     rec_tag;
  logic [BLOCK_BITS-1:0]   rec_data;
  logic                    rec_last;

  logic                    tag_en;
  logic                    tag_wmode;
  logic [SET_W-1:0]        tag_addr;
  logic [TAG_ROW_W-1:0]    tag_wdata;
  logic [TAG_MASK_W-1:0]   tag_wmask;

  logic                    data_en;
  logic                    data_wmode;
  logic [DATA_ADDR_W-1:0]  data_addr;
  logic [DATA_ROW_W-1:0]   data_wdata;
  logic [DATA_MASK_W-1:0]  data_wmask;

  modport master (
    output rec_valid, rec_set, rec_way, rec_tag, rec_data, rec_last,
    input  rec_ready,
    input  tag_en, tag_wmode, tag_addr, tag_wdata, tag_wmask,
    input  data_en, data_wmode, data_addr, data_wdata, data_wmask
  );

  modport slave (
    input  rec_valid, rec_set, rec_way, rec_tag, rec_data, rec_last,
    output rec_ready,
    output tag_en, tag_wmode, tag_addr, tag_wdata, tag_wmask,
    output data_en, data_wmode, data_addr, data_wdata, data_wmask
  );

endinterface

// File: rtl/dcache_warmup_lane_pack.sv
// Replicates a tag and one data beat into every way lane and builds the
// per-way write masks so only the selected way is actually written.
module dcache_warmup_lane_pack
  import dcache_warmup_pkg::*;
(
  input  logic [WAY_W-1:0]       way,
  input  logic [BEAT_W-1:0]      beat,
  input  logic [TAG_BITS-1:0]    tag,
  input  logic [BLOCK_BITS-1:0]  block,
  output logic [TAG_ROW_W-1:0]   tag_wdata,
  output logic [TAG_MASK_W-1:0]  tag_wmask,
  output logic [DATA_ROW_W-1:0]  data_wdata,
  output logic [DATA_MASK_W-1:0] data_wmask
);

  logic [ROW_BITS-1:0] beat_row;

  always_comb begin
    beat_row   = block[int'(beat) * ROW_BITS +: ROW_BITS];
    tag_wdata  = '0;
    data_wdata = '0;
    for (int w = 0; w < WAYS; w++) begin
      tag_wdata[w * TAG_BITS +: TAG_BITS]  = tag;
      data_wdata[w * ROW_BITS +: ROW_BITS] = beat_row;
    end
    tag_wmask  = TAG_MASK_W'(1) << way;
    data_wmask = {{(DATA_MASK_W - ROW_BYTES){1'b0}}, {ROW_BYTES{1'b1}}}
                 << (ROW_BYTES * int'(way));
  end

endmodule

// File: rtl/dcache_warmup_sequencer.sv
// Replays warmup records as real RW0 writes into the dcache tag/data SRAMs,
// optionally clearing all tags first, while holding off the core's own accesses.
module dcache_warmup_sequencer
  import dcache_warmup_pkg::*;
#(
  parameter bit CLEAR_FIRST = 1'b1
)
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  output logic   busy,
  output logic   done,
  output logic   core_hold,
  output state_t dbg_state,
  dcache_warmup_sequencer_if.slave bus
);

  state_t             state;
  logic [SET_W-1:0]   set_cnt;
  logic [BEAT_W-1:0]  beat;
  warmup_rec_t        rec_q;

  logic [TAG_ROW_W-1:0]   pack_tag_wdata;
  logic [TAG_MASK_W-1:0]  pack_tag_wmask;
  logic [DATA_ROW_W-1:0]  pack_data_wdata;
  logic [DATA_MASK_W-1:0] pack_data_wmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      set_cnt <= '0;
      beat    <= '0;
      rec_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          set_cnt <= '0;
          if (start) state <= CLEAR_FIRST ? ST_CLEAR : ST_ACCEPT;
        end
        ST_CLEAR: begin
          set_cnt <= set_cnt + 1'b1;
          if (set_cnt == SET_W'(SETS - 1)) state <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          if (bus.rec_valid) begin
            rec_q.set  <= bus.rec_set;
            rec_q.way  <= bus.rec_way;
            rec_q.tag  <= bus.rec_tag;
            rec_q.data <= bus.rec_data;
            rec_q.last <= bus.rec_last;
            beat       <= '0;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          beat <= beat + 1'b1;
          if (beat == BEAT_W'(BEATS - 1)) state <= rec_q.last ? ST_DONE : ST_ACCEPT;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  dcache_warmup_lane_pack u_lane_pack (
    .way        (rec_q.way),
    .beat       (beat),
    .tag        (rec_q.tag),
    .block      (rec_q.data),
    .tag_wdata  (pack_tag_wdata),
    .tag_wmask  (pack_tag_wmask),
    .data_wdata (pack_data_wdata),
    .data_wmask (pack_data_wmask)
  );

  // Array ports depend only on flops, so rec_* never reaches the SRAMs
  // combinationally; outside CLEAR/WRITE every port field is driven to zero.
  logic                   tag_en_d;
  logic [SET_W-1:0]       tag_addr_d;
  logic [TAG_ROW_W-1:0]   tag_wdata_d;
  logic [TAG_MASK_W-1:0]  tag_wmask_d;
  logic                   data_en_d;
  logic [DATA_ADDR_W-1:0] data_addr_d;
  logic [DATA_ROW_W-1:0]  data_wdata_d;
  logic [DATA_MASK_W-1:0] data_wmask_d;

  always_comb begin
    tag_en_d     = 1'b0;
    tag_addr_d   = '0;
    tag_wdata_d  = '0;
    tag_wmask_d  = '0;
    data_en_d    = 1'b0;
    data_addr_d  = '0;
    data_wdata_d = '0;
    data_wmask_d = '0;
    case (state)
      ST_CLEAR: begin
        tag_en_d    = 1'b1;
        tag_addr_d  = set_cnt;
        tag_wmask_d = '1;
      end
      ST_WRITE: begin
        data_en_d    = 1'b1;
        data_addr_d  = {rec_q.set, beat};
        data_wdata_d = pack_data_wdata;
        data_wmask_d = pack_data_wmask;
        if (beat == '0) begin
          tag_en_d    = 1'b1;
          tag_addr_d  = rec_q.set;
          tag_wdata_d = pack_tag_wdata;
          tag_wmask_d = pack_tag_wmask;
        end
      end
      default: ;
    endcase
  end

  assign bus.tag_en     = tag_en_d;
  assign bus.tag_wmode  = tag_en_d;
  assign bus.tag_addr   = tag_addr_d;
  assign bus.tag_wdata  = tag_wdata_d;
  assign bus.tag_wmask  = tag_wmask_d;
  assign bus.data_en    = data_en_d;
  assign bus.data_wmode = data_en_d;
  assign bus.data_addr  = data_addr_d;
  assign bus.data_wdata = data_wdata_d;
  assign bus.data_wmask = data_wmask_d;

  assign bus.rec_ready = (state == ST_ACCEPT);
  assign busy          = (state != ST_IDLE);
  assign core_hold     = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_dcache_warmup_sequencer.sv
// Directed bench for dcache_warmup_sequencer: expected SRAM writes are queued
// as records are issued and a negedge monitor pops and compares them.
module tb_dcache_warmup_sequencer;
  import dcache_warmup_pkg::*;

  localparam int TAG_ITEM_W  = 1 + SET_W + TAG_ROW_W + TAG_MASK_W;
  localparam int DATA_ITEM_W = 1 + DATA_ADDR_W + DATA_ROW_W + DATA_MASK_W;

  // ---------------- clock / reset / DUT ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  logic   busy, done, core_hold;
  state_t dbg_state;

  dcache_warmup_sequencer_if bus_if ();

  dcache_warmup_sequencer #(.CLEAR_FIRST(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .core_hold (core_hold),
    .dbg_state (dbg_state),
    .bus       (bus_if.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [TAG_ITEM_W-1:0]  tag_exp_q[$];
  logic [DATA_ITEM_W-1:0] data_exp_q[$];
  int   tag_wr_cyc = 0;
  int   done_cyc   = 0;
  int   done_cnt   = 0;
  logic done_prev  = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every SRAM write must match the head of its expected queue.
  always @(negedge clk) begin
    logic [TAG_ITEM_W-1:0]  t_exp;
    logic [DATA_ITEM_W-1:0] d_exp;
    if (bus_if.tag_en) begin
      if (tag_exp_q.size() == 0) flag_fail("unexpected tag write");
      else begin
        t_exp = tag_exp_q.pop_front();
        check("tag write", {bus_if.tag_wmode, bus_if.tag_addr, bus_if.tag_wdata, bus_if.tag_wmask}, t_exp);
        tag_wr_cyc = cyc;
      end
    end
    if (bus_if.data_en) begin
      if (data_exp_q.size() == 0) flag_fail("unexpected data write");
      else begin
        d_exp = data_exp_q.pop_front();
        check("data write", {bus_if.data_wmode, bus_if.data_addr, bus_if.data_wdata, bus_if.data_wmask}, d_exp);
      end
    end
    if (bus_if.rec_ready) check("no array access in accept", {bus_if.tag_en, bus_if.data_en}, 2'b00);
    if (done_prev) check("hold released after done", {busy, core_hold}, 2'b00);
    if (done) begin
      check("hold during done", core_hold, 1'b1);
      done_cyc = cyc;
      done_cnt++;
    end
    done_prev = done;
  end

  // ---------------- driver tasks ----------------
  task automatic push_clear();
    for (int s = 0; s < SETS; s++) tag_exp_q.push_back({1'b1, SET_W'(s), {TAG_ROW_W{1'b0}}, 4'hF});
  endtask

  // Called at a negedge with the DUT idle; returns samples until rec_ready.
  task automatic run_clear(output int n);
    push_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!bus_if.rec_ready && n < 200) begin
      start = (n == 10);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  // Presents a record, waits for the handshake and queues its expected writes.
  task automatic send_rec(input logic [SET_W-1:0] set, input logic [WAY_W-1:0] way,
                          input logic [TAG_BITS-1:0] tag, input logic [BLOCK_BITS-1:0] data,
                          input logic last, input logic [3:0] exp_tmask,
                          input logic [31:0] exp_dmask, output int hs);
    int n;
    bus_if.rec_set   = set;
    bus_if.rec_way   = way;
    bus_if.rec_tag   = tag;
    bus_if.rec_data  = data;
    bus_if.rec_last  = last;
    bus_if.rec_valid = 1'b1;
    n = 0;
    while (!bus_if.rec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.rec_ready) flag_fail("handshake timeout");
    hs = cyc;
    tag_exp_q.push_back({1'b1, set, {WAYS{tag}}, exp_tmask});
    for (int b = 0; b < BEATS; b++)
      data_exp_q.push_back({1'b1, DATA_ADDR_W'(int'(set) * 8 + b), {WAYS{data[64*b +: 64]}}, exp_dmask});
    @(negedge clk);
  endtask

  task automatic wait_done();
    int start_cnt;
    int n;
    start_cnt = done_cnt;
    n = 0;
    while (done_cnt == start_cnt && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start_cnt) flag_fail("done timeout");
    @(negedge clk);
  endtask

  function automatic logic [BLOCK_BITS-1:0] make_block(input logic [31:0] hi);
    logic [BLOCK_BITS-1:0] blk;
    blk = '0;
    for (int b = 0; b < BEATS; b++) blk[64*b +: 64] = {hi + 32'(b), 32'hCAFE_0000 + 32'(b)};
    return blk;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, hs_a, hs_b, hs_c, hs_d, hs_e, hs_f;
    logic [BLOCK_BITS-1:0] blk_a;

    bus_if.rec_valid = 1'b0;
    bus_if.rec_set   = '0;
    bus_if.rec_way   = '0;
    bus_if.rec_tag   = '0;
    bus_if.rec_data  = '0;
    bus_if.rec_last  = 1'b0;

    repeat (3) @(negedge clk);
    check("reset controls", {busy, done, core_hold, bus_if.rec_ready, bus_if.tag_en, bus_if.data_en,
                             bus_if.tag_wmode, bus_if.data_wmode}, 8'h00);
    check("reset tag port", {bus_if.tag_addr, bus_if.tag_wdata, bus_if.tag_wmask}, '0);
    check("reset data port", {bus_if.data_addr, bus_if.data_wdata, bus_if.data_wmask}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // rec_valid in IDLE is ignored
    bus_if.rec_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle ignores rec_valid", {bus_if.rec_ready, busy, core_hold}, 3'b000);
    end
    bus_if.rec_valid = 1'b0;
    check("idle state", dbg_state, ST_IDLE);

    // Tag clear; a second start pulse lands mid-clear and must be ignored
    run_clear(n);
    check("clear length to rec_ready", n, 65);
    check("busy/hold in accept", {busy, core_hold}, 2'b11);

    // Single record
    blk_a = '0;
    for (int b = 0; b < BEATS; b++) blk_a[64*b +: 64] = 64'h1111_1111_1111_1111 * 64'(b);
    send_rec(6'd5, 2'd2, 22'h2ABCDE, blk_a, 1'b1, 4'b0100, 32'h00FF_0000, hs_a);
    bus_if.rec_valid = 1'b0;
    wait_done();
    check("single tag write cycle", tag_wr_cyc - hs_a, 1);
    check("single done latency", done_cyc - hs_a, 9);
    @(negedge clk);
    check("idle after single", {busy, dbg_state}, {1'b0, ST_IDLE});

    // Three back-to-back records with rec_valid held high
    run_clear(n);
    check("second clear length", n, 65);
    send_rec(6'd1,  2'd0, 22'h000123, make_block(32'hB000_0000), 1'b0, 4'b0001, 32'h0000_00FF, hs_b);
    send_rec(6'd2,  2'd1, 22'h155555, make_block(32'hC000_0000), 1'b0, 4'b0010, 32'h0000_FF00, hs_c);
    send_rec(6'd10, 2'd3, 22'h3FFFFF, make_block(32'hD000_0000), 1'b1, 4'b1000, 32'hFF00_0000, hs_d);
    bus_if.rec_valid = 1'b0;
    wait_done();
    check("b2b spacing 1", hs_c - hs_b, 9);
    check("b2b spacing 2", hs_d - hs_c, 9);
    check("b2b done after third", done_cyc - hs_d, 9);

    // Reset asserted during WRITE beat 3
    run_clear(n);
    check("third clear length", n, 65);
    send_rec(6'd7, 2'd1, 22'h0F0F0F, make_block(32'hE000_0000), 1'b1, 4'b0010, 32'h0000_FF00, hs_e);
    bus_if.rec_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async reset mid-write", {bus_if.tag_en, bus_if.data_en, busy, core_hold, bus_if.rec_ready, done}, 6'b0);
    check("beats abandoned by reset", data_exp_q.size(), 4);
    check("tag writes left at reset", tag_exp_q.size(), 0);
    data_exp_q.delete();
    repeat (4) @(negedge clk);
    check("state during reset", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh session after reset; way 3 / set 63 boundary; start while busy ignored
    run_clear(n);
    check("clear after reset", n, 65);
    send_rec(6'd63, 2'd3, 22'h3C0F0F, make_block(32'hF000_0000), 1'b1, 4'b1000, 32'hFF00_0000, hs_f);
    bus_if.rec_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("boundary tag write cycle", tag_wr_cyc - hs_f, 1);
    check("boundary done latency", done_cyc - hs_f, 9);

    repeat (3) @(negedge clk);
    check("final idle", {busy, core_hold, dbg_state}, {2'b00, ST_IDLE});
    check("tag queue drained", tag_exp_q.size(), 0);
    check("data queue drained", data_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
